// File: rtl/memory_port_arbiter_if.sv
// Signal bundle around memory_port_arbiter: CPU and external requester ports,
// the shared data-memory port and the pause line. The arbiter uses the slave modport.
interface memory_port_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [2:0]  cpu_mode;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;

  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt;
  logic        ext_rvalid;
  logic [31:0] ext_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_read_mode;
  logic [2:0]  mem_write_mode;
  logic [31:0] mem_rdata;
  logic        pause;

  modport slave (
    input  cpu_req, cpu_we, cpu_mode, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_addr, mem_wdata, mem_read_mode, mem_write_mode, pause
  );

  modport master (
    output cpu_req, cpu_we, cpu_mode, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_addr, mem_wdata, mem_read_mode, mem_write_mode, pause
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// Serialises CPU and external word accesses onto the shared data-memory port.
// Define ARB_FAIRNESS_EN to bound how long a waiting CPU request can be held off by EXT.
module memory_port_arbiter #(
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned MAX_EXT_BURST = 4
) (
  input logic                  clk,
  input logic                  rst,
  memory_port_arbiter_if.slave bus
);

  localparam logic [2:0] MODE_NONE = 3'd0;
  localparam logic [2:0] MODE_WORD = 3'd3;
  localparam logic [2:0] LAT_LAST  = 3'(READ_LATENCY);

  if ((READ_LATENCY < 1) || (READ_LATENCY > 7) ||
      (MAX_EXT_BURST < 1) || (MAX_EXT_BURST > 15)) begin : g_bad_params
    $error("memory_port_arbiter: READ_LATENCY or MAX_EXT_BURST out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t      state_r,      state_nxt_s;
  logic        owner_ext_r,  owner_ext_nxt_s;
  logic [2:0]  lat_cnt_r,    lat_cnt_nxt_s;
  logic [31:0] addr_r,       addr_nxt_s;
  logic [31:0] wdata_r,      wdata_nxt_s;
  logic        cpu_gnt_r,    cpu_gnt_nxt_s;
  logic        ext_gnt_r,    ext_gnt_nxt_s;
  logic        cpu_rvalid_r, cpu_rvalid_nxt_s;
  logic        ext_rvalid_r, ext_rvalid_nxt_s;
  logic [31:0] cpu_rdata_r,  cpu_rdata_nxt_s;
  logic [31:0] ext_rdata_r,  ext_rdata_nxt_s;
  logic [2:0]  rd_mode_r,    rd_mode_nxt_s;
  logic [2:0]  wr_mode_r,    wr_mode_nxt_s;
  logic        pause_r,      pause_nxt_s;

  logic        any_req_s;
  logic        ext_wins_s;
  logic        win_we_s;
  logic [2:0]  win_mode_s;
  logic [31:0] win_addr_s;
  logic [31:0] win_wdata_s;

  assign any_req_s = bus.cpu_req | bus.ext_req;

`ifdef ARB_FAIRNESS_EN
  localparam logic [3:0] BURST_MAX = 4'(MAX_EXT_BURST);
  logic [3:0] burst_r;

  // EXT keeps priority until it has used its burst allowance against a waiting CPU
  always_comb begin
    if ((burst_r == BURST_MAX) && bus.cpu_req) begin
      ext_wins_s = 1'b0;
    end else begin
      ext_wins_s = bus.ext_req;
    end
  end

  // Consecutive EXT grants, saturating; any CPU grant restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_r <= 4'd0;
    end else if ((state_r == ST_IDLE) && any_req_s) begin
      if (!ext_wins_s) begin
        burst_r <= 4'd0;
      end else if (burst_r != BURST_MAX) begin
        burst_r <= burst_r + 4'd1;
      end else begin
        burst_r <= burst_r;
      end
    end else begin
      burst_r <= burst_r;
    end
  end
`else
  // Strict EXT priority: CPU wins only when EXT is not asking
  always_comb begin
    ext_wins_s = bus.ext_req;
  end
`endif

  // Select the winning requester's fields; EXT accesses are always WORD sized
  always_comb begin
    if (ext_wins_s) begin
      win_we_s    = bus.ext_we;
      win_mode_s  = MODE_WORD;
      win_addr_s  = bus.ext_addr;
      win_wdata_s = bus.ext_wdata;
    end else begin
      win_we_s    = bus.cpu_we;
      win_mode_s  = bus.cpu_mode;
      win_addr_s  = bus.cpu_addr;
      win_wdata_s = bus.cpu_wdata;
    end
  end

  // Next state plus next value of every output register (outputs are all flopped)
  always_comb begin
    state_nxt_s      = state_r;
    owner_ext_nxt_s  = owner_ext_r;
    lat_cnt_nxt_s    = lat_cnt_r;
    addr_nxt_s       = addr_r;
    wdata_nxt_s      = wdata_r;
    cpu_gnt_nxt_s    = 1'b0;
    ext_gnt_nxt_s    = 1'b0;
    cpu_rvalid_nxt_s = 1'b0;
    ext_rvalid_nxt_s = 1'b0;
    cpu_rdata_nxt_s  = cpu_rdata_r;
    ext_rdata_nxt_s  = ext_rdata_r;
    rd_mode_nxt_s    = MODE_NONE;
    wr_mode_nxt_s    = MODE_NONE;
    pause_nxt_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          owner_ext_nxt_s = ext_wins_s;
          addr_nxt_s      = win_addr_s;
          wdata_nxt_s     = win_wdata_s;
          lat_cnt_nxt_s   = 3'd1;
          cpu_gnt_nxt_s   = ~ext_wins_s;
          ext_gnt_nxt_s   = ext_wins_s;
          pause_nxt_s     = ext_wins_s;
          if (win_we_s) begin
            state_nxt_s   = ST_WRITE;
            wr_mode_nxt_s = win_mode_s;
          end else begin
            state_nxt_s   = ST_READ;
            rd_mode_nxt_s = win_mode_s;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_nxt_s = ST_IDLE;
      end
      ST_READ: begin
        pause_nxt_s = owner_ext_r;
        if (lat_cnt_r == LAT_LAST) begin
          state_nxt_s      = ST_RESP;
          cpu_rvalid_nxt_s = ~owner_ext_r;
          ext_rvalid_nxt_s = owner_ext_r;
          if (owner_ext_r) begin
            ext_rdata_nxt_s = bus.mem_rdata;
          end else begin
            cpu_rdata_nxt_s = bus.mem_rdata;
          end
        end else begin
          lat_cnt_nxt_s = lat_cnt_r + 3'd1;
          rd_mode_nxt_s = rd_mode_r;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      owner_ext_r  <= 1'b0;
      lat_cnt_r    <= 3'd0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      cpu_gnt_r    <= 1'b0;
      ext_gnt_r    <= 1'b0;
      cpu_rvalid_r <= 1'b0;
      ext_rvalid_r <= 1'b0;
      cpu_rdata_r  <= 32'd0;
      ext_rdata_r  <= 32'd0;
      rd_mode_r    <= MODE_NONE;
      wr_mode_r    <= MODE_NONE;
      pause_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      owner_ext_r  <= owner_ext_nxt_s;
      lat_cnt_r    <= lat_cnt_nxt_s;
      addr_r       <= addr_nxt_s;
      wdata_r      <= wdata_nxt_s;
      cpu_gnt_r    <= cpu_gnt_nxt_s;
      ext_gnt_r    <= ext_gnt_nxt_s;
      cpu_rvalid_r <= cpu_rvalid_nxt_s;
      ext_rvalid_r <= ext_rvalid_nxt_s;
      cpu_rdata_r  <= cpu_rdata_nxt_s;
      ext_rdata_r  <= ext_rdata_nxt_s;
      rd_mode_r    <= rd_mode_nxt_s;
      wr_mode_r    <= wr_mode_nxt_s;
      pause_r      <= pause_nxt_s;
    end
  end

  assign bus.cpu_gnt        = cpu_gnt_r;
  assign bus.ext_gnt        = ext_gnt_r;
  assign bus.cpu_rvalid     = cpu_rvalid_r;
  assign bus.ext_rvalid     = ext_rvalid_r;
  assign bus.cpu_rdata      = cpu_rdata_r;
  assign bus.ext_rdata      = ext_rdata_r;
  assign bus.mem_addr       = addr_r;
  assign bus.mem_wdata      = wdata_r;
  assign bus.mem_read_mode  = rd_mode_r;
  assign bus.mem_write_mode = wr_mode_r;
  assign bus.pause          = pause_r;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: directed scenarios then random traffic, all outputs
// compared every cycle against a transaction-timeline model of the arbiter.
module tb_memory_port_arbiter;
  localparam int L    = 2;
  localparam int MAXB = 4;
  localparam logic [2:0] NONE = 3'd0;
  localparam logic [2:0] BYTE = 3'd1;
  localparam logic [2:0] WORD = 3'd3;

  logic clk = 1'b0;
  logic rst;
  memory_port_arbiter_if bus();

  memory_port_arbiter #(.READ_LATENCY(L), .MAX_EXT_BURST(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int t = 0;

  // requester intent
  bit          rand_en;
  bit          cpu_want, cpu_hold, cpu_we_v;
  logic [2:0]  cpu_mode_v;
  logic [31:0] cpu_addr_v, cpu_wdata_v;
  bit          ext_want, ext_hold, ext_we_v;
  logic [31:0] ext_addr_v, ext_wdata_v;

  // reference model: the one transaction that currently owns (or last owned) the port
  bit          tx_v, tx_ext, tx_we;
  int          tx_g, idle_from, burst, rcnt;
  logic [2:0]  tx_mode;
  logic [31:0] tx_addr, tx_wdata, prev_addr, prev_wdata, exp_cpu_rdata, exp_ext_rdata;

  int seen_cpu_gnt, seen_ext_gnt, seen_cpu_rv, base_c, base_e, base_rv, ext_before;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    if (a == 32'h0000_0200) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    tx_v = 1'b0; idle_from = t + 1; burst = 0;
    prev_addr = 32'd0; prev_wdata = 32'd0;
    exp_cpu_rdata = 32'd0; exp_ext_rdata = 32'd0;
  endtask

  task automatic check_cycle();
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_rm, e_wm;
    logic        e_cg, e_eg, e_cv, e_ev, e_p;
    e_addr = prev_addr; e_wdata = prev_wdata; e_rm = NONE; e_wm = NONE;
    e_cg = 1'b0; e_eg = 1'b0; e_cv = 1'b0; e_ev = 1'b0; e_p = 1'b0;
    if (tx_v && t >= tx_g) begin
      e_addr = tx_addr; e_wdata = tx_wdata;
      if (t == tx_g) begin e_cg = !tx_ext; e_eg = tx_ext; end
      if (tx_we) begin
        if (t == tx_g) begin e_wm = tx_mode; e_p = tx_ext; end
      end else begin
        if (t <= tx_g + L - 1) e_rm = tx_mode;
        if (t <= tx_g + L) e_p = tx_ext;
        if (t == tx_g + L) begin
          if (tx_ext) begin e_ev = 1'b1; exp_ext_rdata = rd_fn(tx_addr); end
          else begin e_cv = 1'b1; exp_cpu_rdata = rd_fn(tx_addr); end
        end
      end
    end
    chk("cpu_gnt", bus.cpu_gnt, e_cg);
    chk("ext_gnt", bus.ext_gnt, e_eg);
    chk("cpu_rvalid", bus.cpu_rvalid, e_cv);
    chk("ext_rvalid", bus.ext_rvalid, e_ev);
    chk("cpu_rdata", bus.cpu_rdata, exp_cpu_rdata);
    chk("ext_rdata", bus.ext_rdata, exp_ext_rdata);
    chk("mem_addr", bus.mem_addr, e_addr);
    chk("mem_wdata", bus.mem_wdata, e_wdata);
    chk("mem_read_mode", {29'd0, bus.mem_read_mode}, {29'd0, e_rm});
    chk("mem_write_mode", {29'd0, bus.mem_write_mode}, {29'd0, e_wm});
    chk("pause", bus.pause, e_p);
  endtask

  task automatic gen_reqs();
    bit cg, eg;
    cg = tx_v && (tx_g == t) && !tx_ext;
    eg = tx_v && (tx_g == t) && tx_ext;
    if (rand_en && !cg) begin
      if (!cpu_want) begin
        if ($urandom_range(0, 3) == 0) begin
          cpu_want = 1'b1; cpu_we_v = 1'($urandom_range(0, 1));
          cpu_mode_v = 3'($urandom_range(1, 3));
          cpu_addr_v = $urandom(); cpu_wdata_v = $urandom();
        end
      end else if ($urandom_range(0, 15) == 0) cpu_want = 1'b0;
    end
    if (rand_en && !eg) begin
      if (!ext_want) begin
        if ($urandom_range(0, 2) == 0) begin
          ext_want = 1'b1; ext_we_v = 1'($urandom_range(0, 1));
          ext_addr_v = $urandom(); ext_wdata_v = $urandom();
        end
      end else if ($urandom_range(0, 31) == 0) ext_want = 1'b0;
    end
    bus.cpu_req = cpu_want; bus.cpu_we = cpu_we_v; bus.cpu_mode = cpu_mode_v;
    bus.cpu_addr = cpu_addr_v; bus.cpu_wdata = cpu_wdata_v;
    bus.ext_req = ext_want; bus.ext_we = ext_we_v;
    bus.ext_addr = ext_addr_v; bus.ext_wdata = ext_wdata_v;
    if (cg && !cpu_hold) cpu_want = 1'b0;
    if (eg && !ext_hold) ext_want = 1'b0;
  endtask

  task automatic arbitrate();
    bit ew;
    if (t >= idle_from && (bus.cpu_req || bus.ext_req)) begin
`ifdef ARB_FAIRNESS_EN
      ew = bus.ext_req && !(burst == MAXB && bus.cpu_req);
`else
      ew = bus.ext_req;
`endif
      if (tx_v) begin prev_addr = tx_addr; prev_wdata = tx_wdata; end
      tx_v = 1'b1; tx_g = t + 1; tx_ext = ew;
      if (ew) begin
        tx_we = ext_we_v; tx_mode = WORD; tx_addr = ext_addr_v; tx_wdata = ext_wdata_v;
        burst = (burst < MAXB) ? burst + 1 : MAXB;
      end else begin
        tx_we = cpu_we_v; tx_mode = cpu_mode_v; tx_addr = cpu_addr_v; tx_wdata = cpu_wdata_v;
        burst = 0;
      end
      idle_from = tx_we ? tx_g + 1 : tx_g + L + 1;
    end
  endtask

  // one clock cycle: check outputs, model the memory, drive this cycle's inputs
  task automatic tick(input bit do_rst);
    @(negedge clk);
    t++;
    check_cycle();
    if (bus.cpu_gnt === 1'b1) seen_cpu_gnt++;
    if (bus.ext_gnt === 1'b1) seen_ext_gnt++;
    if (bus.cpu_rvalid === 1'b1) seen_cpu_rv++;
    if (bus.mem_read_mode !== NONE) rcnt++; else rcnt = 0;
    bus.mem_rdata = (rcnt == L) ? rd_fn(bus.mem_addr) : $urandom();
    gen_reqs();
    rst = do_rst;
    if (do_rst) begin
      model_reset();
      cpu_want = 1'b0; ext_want = 1'b0; cpu_hold = 1'b0; ext_hold = 1'b0;
    end else begin
      arbitrate();
    end
  endtask

  initial begin
    rst = 1'b1; rand_en = 1'b0;
    cpu_want = 1'b0; cpu_hold = 1'b0; cpu_we_v = 1'b0; cpu_mode_v = WORD;
    cpu_addr_v = 32'd0; cpu_wdata_v = 32'd0;
    ext_want = 1'b0; ext_hold = 1'b0; ext_we_v = 1'b0; ext_addr_v = 32'd0; ext_wdata_v = 32'd0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_mode = WORD; bus.cpu_addr = 32'd0;
    bus.cpu_wdata = 32'd0; bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = 32'd0;
    bus.ext_wdata = 32'd0; bus.mem_rdata = 32'd0;
    seen_cpu_gnt = 0; seen_ext_gnt = 0; seen_cpu_rv = 0; rcnt = 0;
    model_reset();

    // reset held two cycles
    tick(1'b1);
    tick(1'b0);
    chk("rst_pause", bus.pause, 1'b0);
    chk("rst_rmode", {29'd0, bus.mem_read_mode}, {29'd0, NONE});

    // CPU byte write
    cpu_want = 1'b1; cpu_we_v = 1'b1; cpu_mode_v = BYTE;
    cpu_addr_v = 32'h0000_0100; cpu_wdata_v = 32'h0000_00AB;
    tick(1'b0);
    tick(1'b0);
    chk("byte_gnt", bus.cpu_gnt, 1'b1);
    chk("byte_wmode", {29'd0, bus.mem_write_mode}, {29'd0, BYTE});
    chk("byte_addr", bus.mem_addr, 32'h0000_0100);
    chk("byte_wdata", bus.mem_wdata, 32'h0000_00AB);
    chk("byte_pause", bus.pause, 1'b0);
    tick(1'b0);
    chk("byte_wmode_end", {29'd0, bus.mem_write_mode}, {29'd0, NONE});

    // EXT word read of 0x200
    ext_want = 1'b1; ext_we_v = 1'b0; ext_addr_v = 32'h0000_0200;
    tick(1'b0);
    tick(1'b0);
    chk("extrd_gnt", bus.ext_gnt, 1'b1);
    chk("extrd_pause1", bus.pause, 1'b1);
    tick(1'b0);
    chk("extrd_pause2", bus.pause, 1'b1);
    tick(1'b0);
    chk("extrd_rvalid", bus.ext_rvalid, 1'b1);
    chk("extrd_rdata", bus.ext_rdata, 32'hDEAD_BEEF);
    chk("extrd_pause3", bus.pause, 1'b1);
    tick(1'b0);
    chk("extrd_pause_end", bus.pause, 1'b0);

    // simultaneous write requests: EXT first, CPU at R+3
    ext_want = 1'b1; ext_we_v = 1'b1; ext_addr_v = 32'h0000_0010; ext_wdata_v = 32'h1111_2222;
    cpu_want = 1'b1; cpu_we_v = 1'b1; cpu_mode_v = WORD;
    cpu_addr_v = 32'h0000_0020; cpu_wdata_v = 32'h3333_4444;
    tick(1'b0);
    tick(1'b0);
    chk("sim_ext_first", bus.ext_gnt, 1'b1);
    chk("sim_cpu_wait", bus.cpu_gnt, 1'b0);
    tick(1'b0);
    tick(1'b0);
    chk("sim_cpu_r3", bus.cpu_gnt, 1'b1);
    tick(1'b0);

    // reset in the second READ cycle of a CPU read
    cpu_want = 1'b1; cpu_we_v = 1'b0; cpu_mode_v = WORD; cpu_addr_v = 32'h0000_0300;
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    base_rv = seen_cpu_rv;
    for (int i = 0; i < 6; i++) tick(1'b0);
    chk("rst_mid_no_rvalid", 32'(seen_cpu_rv - base_rv), 32'd0);

    // CPU withdrawal while EXT read occupies the port
    ext_want = 1'b1; ext_we_v = 1'b0; ext_addr_v = 32'h0000_0400;
    tick(1'b0);
    tick(1'b0);
    base_c = seen_cpu_gnt;
    cpu_want = 1'b1; cpu_we_v = 1'b1; cpu_addr_v = 32'h0000_0500;
    tick(1'b0);
    cpu_want = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b0);
    chk("withdraw_no_gnt", 32'(seen_cpu_gnt - base_c), 32'd0);

    // continuous EXT traffic against a waiting CPU
    tick(1'b1);
    ext_want = 1'b1; ext_hold = 1'b1; ext_we_v = 1'b1;
    ext_addr_v = 32'h0000_0600; ext_wdata_v = 32'hCAFE_0001;
    cpu_want = 1'b1; cpu_we_v = 1'b1; cpu_addr_v = 32'h0000_0700; cpu_wdata_v = 32'hCAFE_0002;
    base_c = seen_cpu_gnt; base_e = seen_ext_gnt;
`ifdef ARB_FAIRNESS_EN
    for (int i = 0; i < 60 && seen_cpu_gnt == base_c; i++) tick(1'b0);
    ext_before = seen_ext_gnt - base_e;
    chk("fair_cpu_gnt", 32'(seen_cpu_gnt - base_c), 32'd1);
    chk("fair_ext_burst", 32'(ext_before), 32'(MAXB));
`else
    for (int i = 0; i < 40; i++) tick(1'b0);
    chk("strict_cpu_starved", 32'(seen_cpu_gnt - base_c), 32'd0);
    chk("strict_ext_busy", 32'(seen_ext_gnt - base_e), 32'd20);
    ext_hold = 1'b0; ext_want = 1'b0;
    for (int i = 0; i < 10 && seen_cpu_gnt == base_c; i++) tick(1'b0);
    chk("strict_cpu_after_drop", 32'(seen_cpu_gnt - base_c), 32'd1);
`endif
    ext_hold = 1'b0; ext_want = 1'b0; cpu_want = 1'b0;
    for (int i = 0; i < 8; i++) tick(1'b0);

    // random traffic with occasional resets
    rand_en = 1'b1;
    for (int i = 0; i < 3000; i++) tick($urandom_range(0, 299) == 0);
    rand_en = 1'b0; cpu_want = 1'b0; ext_want = 1'b0;
    for (int i = 0; i < 12; i++) tick(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
